// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: feeds an external 1-bit full adder LSB first and
// returns the WIDTH-bit sum, final carry and signed overflow over valid/ready.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             ovf_out
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q;
  logic             ovf_q;
  logic             last_bit;

  // Result register shifts right; the newest sum bit enters at the MSB.
  assign res_d    = (res_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Full-adder operands are only driven while bits are being processed.
  assign fa_a   = (state_q == S_RUN) & a_sh_q[0];
  assign fa_b   = (state_q == S_RUN) & b_sh_q[0];
  assign fa_cin = (state_q == S_RUN) & carry_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum_out   = sum_q;
  assign carry_out = carry_out_q;
  assign ovf_out   = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_sh_q     <= a_in;
            b_sh_q     <= b_in;
            carry_q    <= cin_in;
            cnt_q      <= '0;
            res_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          res_q   <= res_d;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + CW'(1);
          // carry_q is the carry into the MSB on the last bit cycle.
          if (last_bit) begin
            out_valid_q <= 1'b1;
            sum_q       <= res_d;
            carry_out_q <= fa_cout;
            ovf_q       <= carry_q ^ fa_cout;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1, with a
// behavioural full adder and an arithmetic reference model.
module tb_serial_adder_ctrl;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  // WIDTH=8 instance signals
  logic       rst8, in_valid8, in_ready8, cin8, out_valid8, out_ready8;
  logic [7:0] a8, b8, sum8;
  logic       fa_a8, fa_b8, fa_cin8, fa_sum8, fa_cout8, cout8, ovf8;
  // WIDTH=1 instance signals
  logic       rst1, in_valid1, in_ready1, cin1, out_valid1, out_ready1;
  logic [0:0] a1, b1, sum1;
  logic       fa_a1, fa_b1, fa_cin1, fa_sum1, fa_cout1, cout1, ovf1;

  assign fa_sum8  = fa_a8 ^ fa_b8 ^ fa_cin8;
  assign fa_cout8 = (fa_a8 & fa_b8) | (fa_a8 & fa_cin8) | (fa_b8 & fa_cin8);
  assign fa_sum1  = fa_a1 ^ fa_b1 ^ fa_cin1;
  assign fa_cout1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a_in(a8), .b_in(b8), .cin_in(cin8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_sum(fa_sum8), .fa_cout(fa_cout8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum_out(sum8), .carry_out(cout8), .ovf_out(ovf8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a_in(a1), .b_in(b1), .cin_in(cin1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_sum(fa_sum1), .fa_cout(fa_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum_out(sum1), .carry_out(cout1), .ovf_out(ovf1)
  );

  exp_t q8[$];
  exp_t q1[$];
  int   rmode = 2;  // out_ready8: 0 random, 1 held low, 2 held high

  // Plain w-bit addition; overflow when equal-signed operands give a different-signed sum.
  function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b, logic c, int acc);
    logic [64:0] m, full;
    exp_t e;
    m      = (65'(1) << w) - 65'(1);
    full   = (65'(a) & m) + (65'(b) & m) + 65'(c);
    e.sum  = 64'(full & m);
    e.cout = full[w];
    e.ovf  = (a[w-1] == b[w-1]) && (full[w-1] != a[w-1]);
    e.acc  = acc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int t = 0;
    @(negedge clk);
    while (!in_ready8 && t < 100) begin @(negedge clk); t++; end
    if (!in_ready8) begin fail_now("accept8"); return; end
    a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1;
    q8.push_back(model(8, 64'(a), 64'(b), c, cyc + 1));
    @(posedge clk); #1 in_valid8 = 1'b0;
  endtask

  task automatic send1(input logic a, input logic b, input logic c);
    int t = 0;
    @(negedge clk);
    while (!in_ready1 && t < 100) begin @(negedge clk); t++; end
    if (!in_ready1) begin fail_now("accept1"); return; end
    a1 = a; b1 = b; cin1 = c; in_valid1 = 1'b1;
    q1.push_back(model(1, 64'(a), 64'(b), c, cyc + 1));
    @(posedge clk); #1 in_valid1 = 1'b0;
  endtask

  task automatic drain8();
    int t = 0;
    while (q8.size() != 0 && t < 300) begin @(negedge clk); t++; end
    if (q8.size() != 0) fail_now("drain8");
  endtask

  task automatic drain1();
    int t = 0;
    while (q1.size() != 0 && t < 300) begin @(negedge clk); t++; end
    if (q1.size() != 0) fail_now("drain1");
  endtask

  initial begin
    out_ready8 = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       out_ready8 = 1'($urandom_range(0, 1));
        1:       out_ready8 = 1'b0;
        default: out_ready8 = 1'b1;
      endcase
    end
  end

  initial begin
    out_ready1 = 1'b0;
    forever begin @(posedge clk); #1 out_ready1 = 1'($urandom_range(0, 1)); end
  end

  // Monitor for WIDTH=8: compares held result every DONE cycle, pops on handshake.
  initial begin
    logic pov = 1'b0;
    forever begin
      @(negedge clk);
      if (rst8) begin
        pov = 1'b0;
      end else begin
        if (out_valid8) begin
          if (q8.size() == 0) begin
            n_chk++;
            $display("FAIL spurious8: out_valid with nothing expected, sum %0h (cycle %0d)", sum8, cyc);
          end else begin
            chk("sum8", 64'(sum8), q8[0].sum);
            chk("cout8", 64'(cout8), 64'(q8[0].cout));
            chk("ovf8", 64'(ovf8), 64'(q8[0].ovf));
            chk("in_ready_done8", 64'(in_ready8), 64'(0));
            if (!pov) chk("latency8", 64'(cyc), 64'(q8[0].acc + 8));
            if (out_ready8) void'(q8.pop_front());
          end
        end
        if (in_ready8) begin
          chk("fa_idle8", 64'({fa_a8, fa_b8, fa_cin8}), 64'(0));
          chk("idle_out8", 64'({out_valid8, sum8, cout8, ovf8}), 64'(0));
        end
        pov = out_valid8;
      end
    end
  end

  initial begin
    logic pov = 1'b0;
    forever begin
      @(negedge clk);
      if (rst1) begin
        pov = 1'b0;
      end else begin
        if (out_valid1) begin
          if (q1.size() == 0) begin
            n_chk++;
            $display("FAIL spurious1: out_valid with nothing expected (cycle %0d)", cyc);
          end else begin
            chk("sum1", 64'(sum1), q1[0].sum);
            chk("cout1", 64'(cout1), 64'(q1[0].cout));
            chk("ovf1", 64'(ovf1), 64'(q1[0].ovf));
            if (!pov) chk("latency1", 64'(cyc), 64'(q1[0].acc + 1));
            if (out_ready1) void'(q1.pop_front());
          end
        end
        if (in_ready1) chk("fa_idle1", 64'({fa_a1, fa_b1, fa_cin1}), 64'(0));
        pov = out_valid1;
      end
    end
  end

  task automatic seq8();
    int t;
    rst8 = 1'b1; in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready8", 64'(in_ready8), 64'(1));
    chk("rst_outs8", 64'({out_valid8, sum8, cout8, ovf8}), 64'(0));
    chk("rst_fa8", 64'({fa_a8, fa_b8, fa_cin8}), 64'(0));
    @(posedge clk); #1 rst8 = 1'b0;

    rmode = 2;
    send8(8'h5A, 8'h3C, 1'b0);
    send8(8'hFF, 8'h01, 1'b0);
    send8(8'h7F, 8'h00, 1'b1);
    drain8();

    // Backpressure in DONE with in_valid pulses that must be ignored.
    rmode = 1;
    send8(8'h12, 8'h34, 1'b1);
    t = 0;
    while (!out_valid8 && t < 50) begin @(negedge clk); t++; end
    if (!out_valid8) fail_now("bp_valid8");
    a8 = 8'hAA; b8 = 8'h55; in_valid8 = 1'b1;
    repeat (5) @(negedge clk);
    in_valid8 = 1'b0;
    rmode = 2;
    drain8();
    send8(8'h80, 8'h80, 1'b0);
    drain8();

    // Reset mid-RUN: partial result discarded.
    send8(8'h0F, 8'h01, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst8 = 1'b1;
    q8.delete();
    @(posedge clk); #1 rst8 = 1'b0;
    @(negedge clk);
    chk("abort_in_ready8", 64'(in_ready8), 64'(1));
    chk("abort_out_valid8", 64'(out_valid8), 64'(0));
    repeat (12) @(negedge clk);
    send8(8'h01, 8'h01, 1'b0);
    drain8();

    rmode = 0;
    repeat (150) send8(8'($urandom), 8'($urandom), 1'($urandom));
    drain8();
  endtask

  task automatic seq1();
    rst1 = 1'b1; in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst1 = 1'b0;
    send1(1'b1, 1'b1, 1'b0);
    repeat (40) send1(1'($urandom), 1'($urandom), 1'($urandom));
    drain1();
  endtask

  initial begin
    fork
      seq8();
      seq1();
    join
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
